// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle from the timing generator to the renderer/DAC.
//   master (generator) drives every signal; slave (renderer) samples them.
//   pixel_x/pixel_y : current raster coordinate (h, v)
//   video_on        : coordinate lies in the visible 640x480 region
//   hsync/vsync     : active-low syncs
//   pix_en          : one-clk strobe on the last clk of each pixel period
//   frame_start     : one-clk strobe on the last pixel of the frame
//   vga_clk         : DAC pixel clock, vga_blank_n / vga_sync_n : DAC controls
interface vga_timing_if;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       video_on;
   logic       hsync;
   logic       vsync;
   logic       pix_en;
   logic       frame_start;
   logic       vga_clk;
   logic       vga_blank_n;
   logic       vga_sync_n;

   modport master (
      output pixel_x, pixel_y, video_on, hsync, vsync, pix_en,
             frame_start, vga_clk, vga_blank_n, vga_sync_n
   );
   modport slave (
      input  pixel_x, pixel_y, video_on, hsync, vsync, pix_en,
             frame_start, vga_clk, vga_blank_n, vga_sync_n
   );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster timing generator running from the system
// clock with an internal pixel-rate clock enable (one pixel per CLK_DIV clk).
//   clk   : system clock
//   reset : asynchronous, active-low
//   vga   : vga_timing_if.master -- coordinates, visible flag, syncs, strobes
// All decodes are combinational from the counter registers so they always
// line up with pixel_x/pixel_y.
module vga_timing #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int CLK_DIV   = 2
) (
   input  logic         clk,
   input  logic         reset,
   vga_timing_if.master vga
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h;
   logic [9:0]       v;
   logic             tick;
   logic             h_wrap;
   logic             v_wrap;

   assign tick   = (div_cnt == DIV_LAST);
   assign h_wrap = (h == H_LAST);
   assign v_wrap = (v == V_LAST);

   // Reset parks the raster on the last pixel of the frame so the first tick
   // after release both raises frame_start and lands on (0,0).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= '0;
         h       <= H_LAST;
         v       <= V_LAST;
      end else begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) begin
            if (h_wrap) begin
               h <= '0;
               v <= v_wrap ? '0 : v + 10'd1;
            end else begin
               h <= h + 10'd1;
            end
         end
      end
   end

   always_comb begin
      vga.pixel_x     = h;
      vga.pixel_y     = v;
      vga.video_on    = (h < H_VIS) && (v < V_VIS);
      vga.hsync       = !((h >= HS_START) && (h < HS_END));
      vga.vsync       = !((v >= VS_START) && (v < VS_END));
      vga.pix_en      = tick;
      vga.frame_start = tick && h_wrap && v_wrap;
      // High in the second half of the pixel period: falls with the
      // coordinate update, rises mid-pixel when colour is stable.
      vga.vga_clk     = (div_cnt >= DIV_HALF);
      vga.vga_blank_n = (h < H_VIS) && (v < V_VIS);
      vga.vga_sync_n  = 1'b0;
   end
endmodule
